mux4_sel_reg: RTL and testbench

- 4:1 data selector: one of four DATA_W-bit input lanes, chosen by a 2-bit select, drives the output.
- Provides a combinational output Y for zero-latency use.
- Provides a registered copy y_q, with the select echoed on s_q, for timing-closed downstream consumers.
- Sits at the leaf level of datapath steering logic; the default configuration (DATA_W=1) is a plain 4-bit-in, 1-bit-out mux.

---
 rtl/mux_pkg.sv | 13 +
 rtl/mux4_sel_reg_if.sv | 34 +++
 rtl/mux4_core.sv | 28 ++
 rtl/mux4_sel_reg.sv | 46 ++++
 tb/tb_mux4_sel_reg.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the 4:1 lane selector.
//   SEL_W       : width of a lane select code
//   SEL_L0..L3  : named select codes for lanes 0..3
package mux_pkg;

  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_L0 = 2'd0;
  localparam logic [SEL_W-1:0] SEL_L1 = 2'd1;
  localparam logic [SEL_W-1:0] SEL_L2 = 2'd2;
  localparam logic [SEL_W-1:0] SEL_L3 = 2'd3;

endpackage

// File: rtl/mux4_sel_reg_if.sv
// Bus bundle for mux4_sel_reg.
//   I   : 4 packed lanes, lane k = I[k*DATA_W +: DATA_W], lane 0 at the LSBs
//   S   : lane select
//   en  : capture enable for the registered path
//   Y   : combinational selected lane
//   y_q : registered selected lane
//   s_q : select captured together with y_q
// Handshake: there is no valid/ready pair. en is a one-way qualifier with no
// backpressure; the block captures on every rising clk edge where en is 1
// and can never refuse or stall a capture.
interface mux4_sel_reg_if
  import mux_pkg::*;
#(
  parameter int DATA_W = 1
);

  logic [4*DATA_W-1:0] I;
  logic [SEL_W-1:0]    S;
  logic                en;
  logic [DATA_W-1:0]   Y;
  logic [DATA_W-1:0]   y_q;
  logic [SEL_W-1:0]    s_q;

  modport master (
    output I, S, en,
    input  Y, y_q, s_q
  );

  modport slave (
    input  I, S, en,
    output Y, y_q, s_q
  );

endinterface

// File: rtl/mux4_core.sv
// Parameterized combinational 4:1 lane selector.
//   i : 4 packed lanes, lane 0 at the LSBs
//   s : lane select
//   y : selected lane
module mux4_core
  import mux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic [4*DATA_W-1:0] i,
  input  logic [SEL_W-1:0]    s,
  output logic [DATA_W-1:0]   y
);

  always_comb begin
    y = '0;
    case (s)
      SEL_L0:  y = i[0*DATA_W +: DATA_W];
      SEL_L1:  y = i[1*DATA_W +: DATA_W];
      SEL_L2:  y = i[2*DATA_W +: DATA_W];
      SEL_L3:  y = i[3*DATA_W +: DATA_W];
      // Only reachable with X/Z on s in simulation: propagate X rather than
      // silently falling back to lane 0.
      default: y = 'x;
    endcase
  end

endmodule

// File: rtl/mux4_sel_reg.sv
// 4:1 data selector with a combinational output and a registered copy.
//   clk   : rising-edge clock for the registered path
//   rst_n : asynchronous active-low reset, clears y_q/s_q
//   bus   : slave side of mux4_sel_reg_if (I, S, en in; Y, y_q, s_q out)
// Y is the zero-latency selected lane. y_q/s_q capture the selected lane and
// its select on an enabled edge, so they always form a coherent pair.
module mux4_sel_reg
  import mux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mux4_sel_reg_if.slave  bus
);

  logic [DATA_W-1:0] y_sel;
  logic [DATA_W-1:0] y_q_r;
  logic [SEL_W-1:0]  s_q_r;

  mux4_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .i (bus.I),
    .s (bus.S),
    .y (y_sel)
  );

  assign bus.Y = y_sel;

  // The same selector output feeds Y and the register, so y_q can never
  // disagree with the lane that s_q names.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_r <= '0;
      s_q_r <= SEL_L0;
    end else if (bus.en) begin
      y_q_r <= y_sel;
      s_q_r <= bus.S;
    end
  end

  assign bus.y_q = y_q_r;
  assign bus.s_q = s_q_r;

endmodule

// File: tb/tb_mux4_sel_reg.sv
module tb_mux4_sel_reg;

  logic clk;
  logic rst_n;

  int n_vec;
  int n_err;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux4_sel_reg_if #(.DATA_W(1)) bus1 ();
  mux4_sel_reg_if #(.DATA_W(8)) bus8 ();

  mux4_sel_reg #(.DATA_W(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  mux4_sel_reg #(.DATA_W(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  // scoreboard check
  task automatic check_val(input string tag, input logic [7:0] obs,
                           input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive1(input logic [3:0] i_v, input logic [1:0] s_v,
                        input logic en_v);
    bus1.I  = i_v;
    bus1.S  = s_v;
    bus1.en = en_v;
  endtask

  task automatic drive8(input logic [31:0] i_v, input logic [1:0] s_v,
                        input logic en_v);
    bus8.I  = i_v;
    bus8.S  = s_v;
    bus8.en = en_v;
  endtask

  logic [3:0] hold_i [5];
  logic [1:0] hold_s [5];
  logic       hold_y [5];
  logic [7:0] wide_y [4];
  logic [3:0] cnt;
  logic [3:0] iv;

  initial begin
    n_vec = 0;
    n_err = 0;
    hold_i = '{4'h0, 4'hF, 4'h3, 4'hC, 4'h5};
    hold_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    hold_y = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    wide_y = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    rst_n = 1'b0;
    drive1(4'h0, 2'd0, 1'b0);
    drive8(32'h0, 2'd0, 1'b0);
    #2;
    check_val("rst_y_q1", 8'(bus1.y_q), 8'h00);
    check_val("rst_s_q1", 8'(bus1.s_q), 8'h00);
    check_val("rst_y_q8", bus8.y_q, 8'h00);
    check_val("rst_s_q8", 8'(bus8.s_q), 8'h00);

    @(negedge clk);
    rst_n = 1'b1;

    // combinational sweep: count on I every 10 ns, one select per 100 ns
    for (int s = 0; s < 4; s++) begin
      cnt = 4'h0;
      for (int k = 0; k < 10; k++) begin
        drive1(cnt, 2'(s), 1'b0);
        #1;
        check_val($sformatf("sweep_s%0d_i%0d", s, cnt), 8'(bus1.Y),
                  8'((cnt >> s) & 4'h1));
        #9;
        cnt = cnt + 4'h1;
      end
    end

    // exhaustive 16 x 4
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < 4; s++) begin
        iv = 4'(i);
        drive1(iv, 2'(s), 1'b0);
        #1;
        check_val($sformatf("exh_i%0d_s%0d", i, s), 8'(bus1.Y), 8'(iv[s]));
      end
    end
    drive1(4'b0101, 2'd2, 1'b0);
    #1;
    check_val("ex_0101_s2", 8'(bus1.Y), 8'h01);
    drive1(4'b0101, 2'd3, 1'b0);
    #1;
    check_val("ex_0101_s3", 8'(bus1.Y), 8'h00);

    // registered path
    @(negedge clk);
    drive1(4'b1000, 2'd3, 1'b1);
    @(posedge clk);
    #1;
    check_val("reg_y_q", 8'(bus1.y_q), 8'h01);
    check_val("reg_s_q", 8'(bus1.s_q), 8'h03);
    @(negedge clk);
    drive1(4'b1000, 2'd0, 1'b1);
    #1;
    check_val("reg_y_now", 8'(bus1.Y), 8'h00);
    check_val("reg_y_q_old", 8'(bus1.y_q), 8'h01);
    @(posedge clk);
    #1;
    check_val("reg_y_q_new", 8'(bus1.y_q), 8'h00);
    check_val("reg_s_q_new", 8'(bus1.s_q), 8'h00);

    // enable hold
    @(negedge clk);
    drive1(4'b1000, 2'd3, 1'b1);
    @(posedge clk);
    #1;
    check_val("hold_cap_y_q", 8'(bus1.y_q), 8'h01);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive1(hold_i[k], hold_s[k], 1'b0);
      #1;
      check_val($sformatf("hold_y_%0d", k), 8'(bus1.Y), 8'(hold_y[k]));
      @(posedge clk);
      #1;
      check_val($sformatf("hold_y_q_%0d", k), 8'(bus1.y_q), 8'h01);
      check_val($sformatf("hold_s_q_%0d", k), 8'(bus1.s_q), 8'h03);
    end

    // async reset between edges
    @(negedge clk);
    drive1(4'b1000, 2'd3, 1'b1);
    @(posedge clk);
    #1;
    check_val("ar_pre_y_q", 8'(bus1.y_q), 8'h01);
    drive1(4'b0110, 2'd2, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar_y_q", 8'(bus1.y_q), 8'h00);
    check_val("ar_s_q", 8'(bus1.s_q), 8'h00);
    check_val("ar_y_comb", 8'(bus1.Y), 8'h01);
    @(posedge clk);
    #1;
    check_val("ar_held_y_q", 8'(bus1.y_q), 8'h00);
    check_val("ar_held_s_q", 8'(bus1.s_q), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    drive1(4'b0010, 2'd1, 1'b1);
    @(posedge clk);
    #1;
    check_val("ar_rel_y_q", 8'(bus1.y_q), 8'h01);
    check_val("ar_rel_s_q", 8'(bus1.s_q), 8'h01);

    // wide lanes
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      drive8({8'hDD, 8'hCC, 8'hBB, 8'hAA}, 2'(s), 1'b1);
      #1;
      check_val($sformatf("wide_y_s%0d", s), bus8.Y, wide_y[s]);
      @(posedge clk);
      #1;
      check_val($sformatf("wide_y_q_s%0d", s), bus8.y_q, wide_y[s]);
      check_val($sformatf("wide_s_q_s%0d", s), 8'(bus8.s_q), 8'(s));
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
